tmds_encoder_dvi: RTL and testbench

Single-channel DVI 1.0 TMDS encoder: converts one 8-bit colour component plus two control bits into a DC-balanced 10-bit symbol every pixel clock. It sits between the pixel colour logic and the 10:1 serializer inside `dvi_generator`, which instantiates three of them (blue/ch0, green/ch1, red/ch2). It is a fixed two-stage pipeline with a running-disparity register.

---
 rtl/tmds_pkg.sv | 32 +++
 rtl/tmds_encoder_dvi.sv | 103 ++++++++++
 tb/tb_tmds_encoder_dvi.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS constants and helpers for the DVI encoder channels.
// Control codes are listed LSB-last; bit 0 is the first bit on the wire.
package tmds_pkg;

  localparam int TMDS_W = 10;

  localparam logic [TMDS_W-1:0] CTRL_CODE_00 = 10'b1101010100;
  localparam logic [TMDS_W-1:0] CTRL_CODE_01 = 10'b0010101011;
  localparam logic [TMDS_W-1:0] CTRL_CODE_10 = 10'b0101010100;
  localparam logic [TMDS_W-1:0] CTRL_CODE_11 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, d[i]};
    end
    return n;
  endfunction

  function automatic logic [TMDS_W-1:0] ctrl_code(input logic [1:0] c);
    logic [TMDS_W-1:0] code;
    case (c)
      2'b00:   code = CTRL_CODE_00;
      2'b01:   code = CTRL_CODE_01;
      2'b10:   code = CTRL_CODE_10;
      default: code = CTRL_CODE_11;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/tmds_encoder_dvi.sv
// One DVI TMDS channel: transition-minimising stage followed by a DC-balancing
// stage that tracks running disparity; two register stages end to end.
module tmds_encoder_dvi
  import tmds_pkg::*;
#(
  parameter int BIAS_W = 5
) (
  input  logic                     clk_pix,
  input  logic                     rst,
  input  logic                     de,
  input  logic [7:0]               data_in,
  input  logic [1:0]               ctrl_in,
  output logic [TMDS_W-1:0]        tmds,
  output logic signed [BIAS_W-1:0] bias
);

  localparam logic signed [BIAS_W-1:0] EIGHT = BIAS_W'(8);
  localparam logic signed [BIAS_W-1:0] TWO   = BIAS_W'(2);

  // Signed (ones - zeros) of an 8-bit word given its popcount: 2*n1 - 8.
  function automatic logic signed [BIAS_W-1:0] ones_minus_zeros(input logic [3:0] n1);
    logic signed [BIAS_W-1:0] n;
    n = $signed({{(BIAS_W-4){1'b0}}, n1});
    return (n <<< 1) - EIGHT;
  endfunction

  // ---- stage 0 -> 1: transition minimisation ----
  logic [3:0] n1_p0;
  logic       use_xnor_p0;
  logic [8:0] q_m_p0;

  always_comb begin
    n1_p0       = popcount8(data_in);
    use_xnor_p0 = (n1_p0 > 4'd4) || ((n1_p0 == 4'd4) && !data_in[0]);
    q_m_p0      = '0;
    q_m_p0[0]   = data_in[0];
    for (int i = 1; i < 8; i++) begin
      q_m_p0[i] = use_xnor_p0 ? ~(q_m_p0[i-1] ^ data_in[i]) : (q_m_p0[i-1] ^ data_in[i]);
    end
    q_m_p0[8] = ~use_xnor_p0;
  end

  logic [8:0] q_m_p1;
  logic       de_p1;
  logic [1:0] ctrl_p1;

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      q_m_p1  <= '0;
      de_p1   <= 1'b0;
      ctrl_p1 <= 2'b00;
    end else begin
      q_m_p1  <= q_m_p0;
      de_p1   <= de;
      ctrl_p1 <= ctrl_in;
    end
  end

  // ---- stage 1 -> 2: DC balance / control insertion ----
  logic signed [BIAS_W-1:0] diff_p1;
  logic signed [BIAS_W-1:0] bias_next_p1;
  logic [TMDS_W-1:0]        tmds_next_p1;
  logic                     q8_p1;
  logic                     bias_zero_p1, bias_neg_p1, bias_pos_p1;
  logic                     diff_zero_p1, diff_neg_p1, diff_pos_p1;

  always_comb begin
    q8_p1        = q_m_p1[8];
    diff_p1      = ones_minus_zeros(popcount8(q_m_p1[7:0]));
    bias_zero_p1 = (bias == '0);
    bias_neg_p1  = bias[BIAS_W-1];
    bias_pos_p1  = !bias_zero_p1 && !bias_neg_p1;
    diff_zero_p1 = (diff_p1 == '0);
    diff_neg_p1  = diff_p1[BIAS_W-1];
    diff_pos_p1  = !diff_zero_p1 && !diff_neg_p1;
    tmds_next_p1 = ctrl_code(ctrl_p1);
    bias_next_p1 = '0;
    if (de_p1) begin
      if (bias_zero_p1 || diff_zero_p1) begin
        tmds_next_p1 = {~q8_p1, q8_p1, q8_p1 ? q_m_p1[7:0] : ~q_m_p1[7:0]};
        bias_next_p1 = q8_p1 ? (bias + diff_p1) : (bias - diff_p1);
      end else if ((bias_pos_p1 && diff_pos_p1) || (bias_neg_p1 && diff_neg_p1)) begin
        // Invert the payload to pull disparity back toward zero.
        tmds_next_p1 = {1'b1, q8_p1, ~q_m_p1[7:0]};
        bias_next_p1 = bias + (q8_p1 ? TWO : '0) - diff_p1;
      end else begin
        tmds_next_p1 = {1'b0, q8_p1, q_m_p1[7:0]};
        bias_next_p1 = bias + diff_p1 - (q8_p1 ? '0 : TWO);
      end
    end
  end

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      tmds <= CTRL_CODE_00;
      bias <= '0;
    end else begin
      tmds <= tmds_next_p1;
      bias <= bias_next_p1;
    end
  end

endmodule

// File: tb/tb_tmds_encoder_dvi.sv
// Bench for tmds_encoder_dvi: fixed vector table, mid-stream reset, and a
// long random stream checked through a model, a decoder and a disparity bound.
module tb_tmds_encoder_dvi;

  localparam int BIAS_W = 5;

  logic                     clk_pix = 1'b0;
  logic                     rst;
  logic                     de;
  logic [7:0]               data_in;
  logic [1:0]               ctrl_in;
  logic [9:0]               tmds;
  logic signed [BIAS_W-1:0] bias;

  tmds_encoder_dvi #(.BIAS_W(BIAS_W)) dut (
    .clk_pix (clk_pix),
    .rst     (rst),
    .de      (de),
    .data_in (data_in),
    .ctrl_in (ctrl_in),
    .tmds    (tmds),
    .bias    (bias)
  );

  always #5 clk_pix = ~clk_pix;

  typedef struct {
    logic       de;
    logic [7:0] d;
    logic [1:0] c;
    logic [9:0] t;
    int         b;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   model_bias = 0;
  int   out_idx  = 0;

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    case (c)
      2'b00:   return 10'h354;
      2'b01:   return 10'h0AB;
      2'b10:   return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  // Reference encoder; the XOR/XNOR chain is expressed as a running parity.
  function automatic exp_t model(input logic de_i, input logic [7:0] d, input logic [1:0] c);
    exp_t       e;
    int         n, ones, diff;
    logic       xn, par, q8;
    logic [7:0] qm;
    e.de = de_i; e.d = d; e.c = c;
    if (!de_i) begin
      e.t = ctrl_sym(c);
      model_bias = 0;
    end else begin
      n = 0;
      for (int i = 0; i < 8; i++) n += int'(d[i]);
      xn  = (n > 4) || (n == 4 && !d[0]);
      par = 1'b0;
      for (int i = 0; i < 8; i++) begin
        par   = par ^ d[i];
        qm[i] = par ^ (xn && (i % 2 == 1));
      end
      q8   = !xn;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(qm[i]);
      diff = 2 * ones - 8;
      if (model_bias == 0 || diff == 0) begin
        e.t = {~q8, q8, q8 ? qm : ~qm};
        model_bias += q8 ? diff : -diff;
      end else if ((model_bias > 0 && diff > 0) || (model_bias < 0 && diff < 0)) begin
        e.t = {1'b1, q8, ~qm};
        model_bias += 2 * int'(q8) - diff;
      end else begin
        e.t = {1'b0, q8, qm};
        model_bias += diff - 2 * int'(!q8);
      end
    end
    e.b = model_bias;
    return e;
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] t);
    logic [7:0] w, o;
    w    = t[9] ? ~t[7:0] : t[7:0];
    o[0] = w[0];
    for (int i = 1; i < 8; i++) o[i] = t[8] ? (w[i] ^ w[i-1]) : ~(w[i] ^ w[i-1]);
    return o;
  endfunction

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (q.size() >= 2) begin
      e = q.pop_front();
      check($sformatf("tmds[%0d]", out_idx), int'(tmds), int'(e.t));
      check($sformatf("bias[%0d]", out_idx), int'(bias), e.b);
      check($sformatf("bias_bound[%0d]", out_idx), int'((int'(bias) <= 10) && (int'(bias) >= -10)), 1);
      if (e.de) check($sformatf("decode[%0d]", out_idx), int'(decode(tmds)), int'(e.d));
      out_idx++;
    end
  endtask

  task automatic drive(input exp_t e);
    @(negedge clk_pix);
    check_out();
    de      = e.de;
    data_in = e.d;
    ctrl_in = e.c;
    q.push_back(e);
  endtask

  task automatic drive_model(input logic de_i, input logic [7:0] d, input logic [1:0] c);
    drive(model(de_i, d, c));
  endtask

  // Pipeline after reset holds two control-00 symbols.
  task automatic prime_after_reset();
    exp_t r;
    r.de = 1'b0; r.d = 8'h00; r.c = 2'b00; r.t = 10'h354; r.b = 0;
    q.delete();
    q.push_back(r);
    q.push_back(r);
    model_bias = 0;
  endtask

  task automatic reset_mid_stream();
    @(posedge clk_pix);
    #2;
    rst     = 1'b1;
    de      = 1'b0;
    data_in = 8'h00;
    ctrl_in = 2'b00;
    #1;
    check("async_rst_tmds", int'(tmds), 'h354);
    check("async_rst_bias", int'(bias), 0);
    repeat (2) @(negedge clk_pix);
    check("rst_hold_tmds", int'(tmds), 'h354);
    check("rst_hold_bias", int'(bias), 0);
    rst = 1'b0;
    prime_after_reset();
  endtask

  exp_t vecs[16];

  initial begin
    int sent, burst, gap;
    exp_t e;

    vecs[0]  = '{1'b0, 8'h00, 2'b00, 10'h354, 0};
    vecs[1]  = '{1'b0, 8'h00, 2'b01, 10'h0AB, 0};
    vecs[2]  = '{1'b0, 8'h00, 2'b10, 10'h154, 0};
    vecs[3]  = '{1'b0, 8'h00, 2'b11, 10'h2AB, 0};
    vecs[4]  = '{1'b1, 8'h00, 2'b00, 10'h100, -8};
    vecs[5]  = '{1'b1, 8'h00, 2'b00, 10'h3FF, 2};
    vecs[6]  = '{1'b1, 8'h00, 2'b00, 10'h100, -6};
    vecs[7]  = '{1'b0, 8'h00, 2'b00, 10'h354, 0};
    vecs[8]  = '{1'b1, 8'hFF, 2'b00, 10'h200, -8};
    vecs[9]  = '{1'b0, 8'h00, 2'b00, 10'h354, 0};
    vecs[10] = '{1'b1, 8'h55, 2'b00, 10'h133, 0};
    vecs[11] = '{1'b1, 8'h10, 2'b00, 10'h1F0, 0};
    vecs[12] = '{1'b1, 8'h00, 2'b00, 10'h100, -8};
    vecs[13] = '{1'b0, 8'hFF, 2'b01, 10'h0AB, 0};   // de and data change together
    vecs[14] = '{1'b1, 8'hFF, 2'b10, 10'h200, -8};
    vecs[15] = '{1'b0, 8'h00, 2'b11, 10'h2AB, 0};

    rst = 1'b1; de = 1'b0; data_in = 8'h00; ctrl_in = 2'b00;
    #1;
    check("por_tmds", int'(tmds), 'h354);
    check("por_bias", int'(bias), 0);
    repeat (3) @(negedge clk_pix);
    rst = 1'b0;
    prime_after_reset();

    for (int i = 0; i < 16; i++) begin
      e = model(vecs[i].de, vecs[i].d, vecs[i].c);
      drive(vecs[i]);
    end

    sent = 0;
    while (sent < 10000) begin
      burst = $urandom_range(1, 1920);
      if (burst > 10000 - sent) burst = 10000 - sent;
      for (int i = 0; i < burst; i++) begin
        if (sent == 5000) reset_mid_stream();
        drive_model(1'b1, 8'($urandom()), 2'($urandom()));
        sent++;
      end
      gap = $urandom_range(1, 40);
      for (int i = 0; i < gap; i++) drive_model(1'b0, 8'($urandom()), 2'($urandom()));
    end

    @(negedge clk_pix);
    check_out();
    @(negedge clk_pix);
    check_out();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
